// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types, constants and the segment encoding used by the
// 7-segment display driver and its BCD converter.
//   state_t       - converter FSM states (IDLE, SHIFT, COMMIT)
//   SEG_BLANK     - all segments off (active-low)
//   digit_to_seg  - BCD nibble to {g,f,e,d,c,b,a}, active-low
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Nibbles 10-15 cannot come out of a correct double-dabble; show them dark.
    function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter.
// A conversion starts whenever value differs from the last latched value,
// takes one bit per clock, and the result is published only on COMMIT so the
// bcd output never carries partial digits.
//   clk   in   rising-edge clock
//   reset in   synchronous, active-high
//   value in   binary input
//   busy  out  high from the sampling edge through the last shift
//   bcd   out  displayed BCD digits, units in bcd[3:0]
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int BUS_WIDTH = 8,
    parameter int N_DIGITS  = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [BUS_WIDTH-1:0]    value,
    output logic                    busy,
    output logic [4*N_DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(BUS_WIDTH + 1);

    state_t                  state_q, state_d;
    logic [BUS_WIDTH-1:0]    latched_q, latched_d;
    logic [BUS_WIDTH-1:0]    bin_q, bin_d;
    logic [4*N_DIGITS-1:0]   acc_q, acc_d;
    logic [4*N_DIGITS-1:0]   bcd_q, bcd_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic [4*N_DIGITS-1:0]   adj;

    always_comb begin
        state_d   = state_q;
        latched_d = latched_q;
        bin_d     = bin_q;
        acc_d     = acc_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        adj       = acc_q;
        case (state_q)
            IDLE: begin
                if (value != latched_q) begin
                    latched_d = value;
                    bin_d     = value;
                    acc_d     = '0;
                    cnt_d     = CW'(BUS_WIDTH);
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // Add-3 correction on every nibble, then shift the whole
                // {bcd, bin} register one place left.
                for (int i = 0; i < N_DIGITS; i++) begin
                    if (acc_q[4*i +: 4] >= 4'd5)
                        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
                end
                {acc_d, bin_d} = {adj, bin_q} << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1))
                    state_d = COMMIT;
            end
            COMMIT: begin
                bcd_d   = acc_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            latched_q <= '0;
            bin_q     <= '0;
            acc_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            latched_q <= latched_d;
            bin_q     <= bin_d;
            acc_q     <= acc_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
        end
    end

    assign busy = busy_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/seg7_display_driver.sv
// seg7_display_driver: shows an unsigned binary value on a time-multiplexed
// common-anode 7-segment display, with optional leading-zero blanking.
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high
//   value    in   binary value to display
//   blank_lz in   1 = blank leading zeros (units digit always shown)
//   seg      out  {g,f,e,d,c,b,a}, active-low
//   an       out  digit enables, active-low, bit 0 = units
//   busy     out  BCD conversion in progress
module seg7_display_driver
    import seg7_pkg::*;
#(
    parameter int BUS_WIDTH = 8,
    parameter int N_DIGITS  = 3,
    parameter int SCAN_DIV  = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] value,
    input  logic                 blank_lz,
    output logic [6:0]           seg,
    output logic [N_DIGITS-1:0]  an,
    output logic                 busy
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    if (10**N_DIGITS <= 2**BUS_WIDTH - 1) begin : g_bad_digits
        $error("N_DIGITS too small for BUS_WIDTH");
    end
    if (SCAN_DIV < 2) begin : g_bad_div
        $error("SCAN_DIV must be at least 2");
    end

    logic [4*N_DIGITS-1:0] bcd;

    bin2bcd_seq #(
        .BUS_WIDTH (BUS_WIDTH),
        .N_DIGITS  (N_DIGITS)
    ) u_conv (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .busy  (busy),
        .bcd   (bcd)
    );

    logic [PW-1:0]       pre_q, pre_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic [N_DIGITS-1:0] blank;
    logic                blank_run;
    logic [3:0]          dig;
    logic                dig_blank;

    // Scan prescaler and digit index run free of the converter.
    always_comb begin
        pre_d = pre_q + PW'(1);
        idx_d = idx_q;
        if (pre_q == PW'(SCAN_DIV - 1)) begin
            pre_d = '0;
            idx_d = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    // A digit is blank when it and every digit above it are zero; the
    // running AND walks from the top digit down and stops short of units.
    always_comb begin
        blank     = '0;
        blank_run = blank_lz;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            blank_run = blank_run && (bcd[4*i +: 4] == 4'd0);
            blank[i]  = blank_run;
        end
    end

    // Outputs are built from the next index so an and seg move together
    // on the same edge the index advances.
    always_comb begin
        dig       = 4'd0;
        dig_blank = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_d == IW'(i)) begin
                dig       = bcd[4*i +: 4];
                dig_blank = blank[i];
            end
        end
        an_d  = ~(N_DIGITS'(1) << idx_d);
        seg_d = dig_blank ? SEG_BLANK : digit_to_seg(dig);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
            idx_q <= '0;
            an_q  <= ~N_DIGITS'(1);
            seg_q <= digit_to_seg(4'd0);
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_seg7_display_driver.sv
module tb_seg7_display_driver;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                           S9 = 7'b0010000, SB = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] value;
    logic       blank_lz;
    logic [6:0] seg;
    logic [2:0] an;
    logic       busy;

    int total = 0;
    int bad   = 0;

    seg7_display_driver #(
        .BUS_WIDTH (8),
        .N_DIGITS  (3),
        .SCAN_DIV  (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .blank_lz (blank_lz),
        .seg      (seg),
        .an       (an),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] v;
        logic       bl;
        logic [6:0] e0, e1, e2;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Watch one full scan (plus margin) and check what each digit showed.
    task automatic check_digits(input string name, input logic [6:0] e0, e1, e2,
                                output int bhi);
        logic [6:0] d0, d1, d2;
        int badan;
        d0 = 'x; d1 = 'x; d2 = 'x;
        bhi = 0; badan = 0;
        for (int c = 0; c < 13; c++) begin
            cyc();
            if (busy) bhi++;
            case (an)
                3'b110:  d0 = seg;
                3'b101:  d1 = seg;
                3'b011:  d2 = seg;
                default: badan++;
            endcase
        end
        chk({name, "_d0"}, d0, e0);
        chk({name, "_d1"}, d1, e1);
        chk({name, "_d2"}, d2, e2);
        chk({name, "_an"}, badan, 0);
    endtask

    task automatic busy_run(input string name);
        int hi, first;
        hi = 0; first = -1;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (busy) begin
                hi++;
                if (first < 0) first = c;
            end
        end
        chk({name, "_busy_len"}, hi, 9);
        chk({name, "_busy_start"}, first, 0);
    endtask

    initial begin
        int bhi;
        int runs [4];
        int nruns, illegal;
        logic inrun, seen7, seen3;

        vt[0] = '{8'd105, 1'b1, S5, S0, S1};
        vt[1] = '{8'd0,   1'b1, S0, SB, SB};
        vt[2] = '{8'd40,  1'b1, S0, S4, SB};
        vt[3] = '{8'd99,  1'b0, S9, S9, S0};
        vt[4] = '{8'd186, 1'b1, S6, S8, S1};
        vt[5] = '{8'd13,  1'b1, S3, S1, SB};
        vt[6] = '{8'd7,   1'b1, S7, SB, SB};
        vt[7] = '{8'd200, 1'b0, S0, S0, S2};

        // Reset state and free-running scan with value 0, blanking on.
        reset = 1'b1; value = 8'd0; blank_lz = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_an", an, 3'b110);
        chk("rst_seg", seg, S0);
        reset = 1'b0;
        repeat (4) cyc();
        chk("scan1_an", an, 3'b101);
        chk("scan1_seg", seg, SB);
        repeat (4) cyc();
        chk("scan2_an", an, 3'b011);
        chk("scan2_seg", seg, SB);
        repeat (4) cyc();
        chk("scan3_an", an, 3'b110);
        chk("scan3_seg", seg, S0);

        // 0 -> 255: busy length and resulting digits.
        value = 8'd255;
        busy_run("v255");
        repeat (2) cyc();
        check_digits("v255", S5, S5, S2, bhi);

        for (int i = 0; i < 8; i++) begin
            value    = vt[i].v;
            blank_lz = vt[i].bl;
            repeat (12) cyc();
            check_digits($sformatf("vec%0d", i), vt[i].e0, vt[i].e1, vt[i].e2, bhi);
        end

        // 200 -> 37 -> 200 (second change lands mid-conversion).
        for (int k = 0; k < 4; k++) runs[k] = 0;
        nruns = 0; illegal = 0; inrun = 1'b0; seen7 = 1'b0; seen3 = 1'b0;
        value = 8'd37;
        for (int c = 0; c < 40; c++) begin
            cyc();
            if (c == 2) value = 8'd200;
            if (busy) begin
                if (!inrun) nruns++;
                inrun = 1'b1;
                if (nruns >= 1 && nruns <= 4) runs[nruns-1]++;
            end else begin
                inrun = 1'b0;
            end
            case (an)
                3'b110: begin
                    if (seg == S7) seen7 = 1'b1;
                    else if (seg != S0) illegal++;
                end
                3'b101: begin
                    if (seg == S3) seen3 = 1'b1;
                    else if (seg != S0) illegal++;
                end
                3'b011: if (seg != S0 && seg != S2) illegal++;
                default: illegal++;
            endcase
        end
        chk("chg_nruns", nruns, 2);
        chk("chg_run0", runs[0], 9);
        chk("chg_run1", runs[1], 9);
        chk("chg_illegal", illegal, 0);
        chk("chg_seen7", seen7, 1);
        chk("chg_seen3", seen3, 1);
        check_digits("chg_final", S0, S0, S2, bhi);

        // Reset in the middle of converting 255, then resume.
        value = 8'd255;
        repeat (4) cyc();
        reset = 1'b1;
        cyc();
        chk("midrst_busy", busy, 0);
        chk("midrst_an", an, 3'b110);
        chk("midrst_seg", seg, S0);
        reset = 1'b0;
        busy_run("resume");
        repeat (2) cyc();
        check_digits("resume", S5, S5, S2, bhi);

        // Blanking toggle needs no reconversion.
        value = 8'd7; blank_lz = 1'b0;
        repeat (12) cyc();
        check_digits("v7_nb", S7, S0, S0, bhi);
        blank_lz = 1'b1;
        check_digits("v7_bl", S7, SB, SB, bhi);
        chk("v7_bl_busy", bhi, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
